// File: rtl/rf_wb_scheduler_pkg.sv
// Shared CPU definitions for register-file writeback scheduling.
// Holds register-file geometry and the writeback arbiter state type.
package rf_wb_scheduler_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_REGS  = 32;

  typedef enum logic [0:0] {
    WBS_NORMAL,
    WBS_FORCE_LR
  } wbs_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// Bit 0 is hard-wired clear, and set wins over clear on the same index.
module rf_scoreboard
  import rf_wb_scheduler_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_en_i,
  input  logic [REG_IDX_W-1:0] set_idx_i,
  input  logic                 clr_en_i,
  input  logic [REG_IDX_W-1:0] clr_idx_i,
  input  logic [REG_IDX_W-1:0] rd_a_idx_i,
  input  logic [REG_IDX_W-1:0] rd_b_idx_i,
  input  logic [REG_IDX_W-1:0] rd_c_idx_i,
  output logic                 busy_a_o,
  output logic                 busy_b_o,
  output logic                 busy_c_o,
  output logic [NUM_REGS-1:0]  pending_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en_i) set_vec[set_idx_i] = 1'b1;
    if (clr_en_i) clr_vec[clr_idx_i] = 1'b1;
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Reads see only the registered vector; no same-cycle bypass.
  assign busy_a_o  = pending_q[rd_a_idx_i];
  assign busy_b_o  = pending_q[rd_b_idx_i];
  assign busy_c_o  = pending_q[rd_c_idx_i];
  assign pending_o = pending_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single register-file write port between pipeline writeback and
// the long-latency return path, with starvation protection and a hazard scoreboard.
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_valid,
  input  logic [REG_IDX_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]      pipe_data,
  output logic                 pipe_stall,
  input  logic                 lr_valid,
  input  logic [REG_IDX_W-1:0] lr_rd,
  input  logic [XLEN-1:0]      lr_data,
  output logic                 lr_ready,
  input  logic                 iss_valid,
  input  logic                 iss_long,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic [REG_IDX_W-1:0] rs1_index,
  input  logic [REG_IDX_W-1:0] rs2_index,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy,
  output logic                 wb_en,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STARVE_LIMIT - 1);

  wbs_state_e       state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             grant_pipe, grant_lr;
  logic             sb_set;
  logic [NUM_REGS-1:0] pending;

  always_comb begin
    grant_pipe = 1'b0;
    grant_lr   = 1'b0;
    unique case (state_q)
      WBS_NORMAL: begin
        grant_pipe = pipe_valid;
        grant_lr   = lr_valid && !pipe_valid;
      end
      WBS_FORCE_LR: begin
        grant_lr = lr_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    if (grant_pipe) begin
      wb_rd   = pipe_rd;
      wb_data = pipe_data;
    end else if (grant_lr) begin
      wb_rd   = lr_rd;
      wb_data = lr_data;
    end
  end

  // x0 writes are acknowledged to the requester but never reach the register file.
  assign wb_en      = (grant_pipe || grant_lr) && (wb_rd != '0);
  assign lr_ready   = grant_lr;
  assign pipe_stall = (state_q == WBS_FORCE_LR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WBS_NORMAL;
      wait_cnt_q <= '0;
    end else begin
      unique case (state_q)
        WBS_NORMAL: begin
          if (lr_valid && !grant_lr) begin
            if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 1'b1;
            if (wait_cnt_q >= CntLast) state_q <= WBS_FORCE_LR;
          end else begin
            wait_cnt_q <= '0;
          end
        end
        WBS_FORCE_LR: begin
          // Leave after one cycle whether or not LR held its request.
          state_q    <= WBS_NORMAL;
          wait_cnt_q <= '0;
        end
        default: begin
          state_q    <= WBS_NORMAL;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign sb_set = iss_valid && iss_long && (iss_rd != '0);

  rf_scoreboard u_scoreboard (
    .clk_i      (clk),
    .rst_i      (rst),
    .set_en_i   (sb_set),
    .set_idx_i  (iss_rd),
    .clr_en_i   (grant_lr),
    .clr_idx_i  (lr_rd),
    .rd_a_idx_i (rs1_index),
    .rd_b_idx_i (rs2_index),
    .rd_c_idx_i (iss_rd),
    .busy_a_o   (rs1_busy),
    .busy_b_o   (rs2_busy),
    .busy_c_o   (rd_busy),
    .pending_o  (pending)
  );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: directed scenarios then random traffic,
// checked against a cycle-level reference model of the arbitration rules.
module tb_rf_wb_scheduler;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, lr_valid, iss_valid, iss_long;
  logic [4:0]  pipe_rd, lr_rd, iss_rd, rs1_index, rs2_index;
  logic [31:0] pipe_data, lr_data;
  logic        pipe_stall, lr_ready, rs1_busy, rs2_busy, rd_busy, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  rf_wb_scheduler #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .pipe_stall (pipe_stall),
    .lr_valid   (lr_valid),
    .lr_rd      (lr_rd),
    .lr_data    (lr_data),
    .lr_ready   (lr_ready),
    .iss_valid  (iss_valid),
    .iss_long   (iss_long),
    .iss_rd     (iss_rd),
    .rs1_index  (rs1_index),
    .rs2_index  (rs2_index),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rd_busy    (rd_busy),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ready;
    logic        stall;
    logic        b1, b2, bd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: LR starvation streak, forced-drain flag, pending set.
  bit   m_force;
  int   m_streak;
  bit   m_pend[32];

  // LR request held by the driver until accepted.
  bit          lr_hold;
  logic [4:0]  lr_hold_rd;
  logic [31:0] lr_hold_data;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void model_reset();
    m_force  = 1'b0;
    m_streak = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
  endfunction

  // Applies one cycle of inputs, queues the expected outputs, advances the model.
  task automatic step(input bit r, input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input bit iv, input bit il, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2, output bit lr_taken);
    exp_t e;
    bit   gp, gl;
    @(posedge clk);
    #1;
    rst = r; pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    lr_valid = lv; lr_rd = lrd; lr_data = ld;
    iss_valid = iv; iss_long = il; iss_rd = ird; rs1_index = r1; rs2_index = r2;

    gp = !m_force && pv;
    gl = lv && (m_force || !pv);
    e.rd    = gp ? prd : (gl ? lrd : 5'd0);
    e.data  = gp ? pd : (gl ? ld : 32'd0);
    e.wen   = (gp || gl) && (e.rd != 0);
    e.ready = gl;
    e.stall = m_force;
    e.b1    = m_pend[r1];
    e.b2    = m_pend[r2];
    e.bd    = m_pend[ird];
    exp_q.push_back(e);
    lr_taken = gl && !r;

    if (r) begin
      model_reset();
    end else begin
      if (m_force) begin
        m_force  = 1'b0;
        m_streak = 0;
      end else if (lv && !gl) begin
        m_streak++;
        if (m_streak >= STARVE_LIMIT) m_force = 1'b1;
      end else begin
        m_streak = 0;
      end
      if (gl) m_pend[lrd] = 1'b0;
      if (iv && il && ird != 0) m_pend[ird] = 1'b1;
    end
  endtask

  // Monitor: compares every presented output cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wb_en",      32'(wb_en),      32'(e.wen));
      chk("wb_rd",      32'(wb_rd),      32'(e.rd));
      chk("wb_data",    wb_data,         e.data);
      chk("lr_ready",   32'(lr_ready),   32'(e.ready));
      chk("pipe_stall", 32'(pipe_stall), 32'(e.stall));
      chk("rs1_busy",   32'(rs1_busy),   32'(e.b1));
      chk("rs2_busy",   32'(rs2_busy),   32'(e.b2));
      chk("rd_busy",    32'(rd_busy),    32'(e.bd));
    end
  end

  initial begin
    bit tk;
    rst = 1'b1; pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    lr_valid = 0; lr_rd = 0; lr_data = 0;
    iss_valid = 0; iss_long = 0; iss_rd = 0; rs1_index = 0; rs2_index = 0;
    model_reset();
    lr_hold = 0; lr_hold_rd = 0; lr_hold_data = 0;
    repeat (2) @(posedge clk);

    // Idle after reset, then a long-latency issue to x5 shows busy next cycle.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tk);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, tk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, tk);

    // Same-cycle contention: PIPE first, LR next cycle, then x5 clears.
    step(0, 1, 3, 32'hAAAA0001, 1, 5, 32'h1234, 0, 0, 0, 5, 0, tk);
    step(0, 0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 5, 0, tk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, tk);

    // Starvation: PIPE held for six cycles, LR forced in at cycle 4.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 5'(10 + i), 32'h5000 + 32'(i), !tk || i == 0, 12, 32'hBEEF, 0, 0, 0, 12, 0, tk);
    end

    // x0 writes are acknowledged but never enabled; x0 never becomes busy.
    step(0, 0, 0, 0, 1, 0, 32'hFFFF, 1, 1, 0, 0, 0, tk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tk);
    step(0, 1, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, tk);

    // Set wins over clear on x7; clear x7 while setting x9.
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, tk);
    step(0, 0, 0, 0, 1, 7, 32'h71, 1, 1, 7, 7, 0, tk);
    step(0, 0, 0, 0, 1, 7, 32'h72, 1, 1, 9, 7, 9, tk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 7, 9, tk);

    // Reset while forced with x5/x7 pending; held LR re-arbitrated after reset.
    step(0, 0, 0, 0, 1, 9, 32'h99, 1, 1, 5, 5, 7, tk);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 5, 7, tk);
    for (int i = 0; i < 4; i++) step(0, 1, 2, 32'h22, 1, 6, 32'h66, 0, 0, 0, 5, 7, tk);
    step(1, 1, 2, 32'h22, 1, 6, 32'h66, 0, 0, 0, 5, 7, tk);
    step(0, 1, 2, 32'h22, 1, 6, 32'h66, 0, 0, 0, 5, 7, tk);
    step(0, 0, 2, 32'h22, 1, 6, 32'h66, 0, 0, 0, 5, 7, tk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, tk);

    // Random traffic with a protocol-respecting LR source.
    for (int n = 0; n < 2000; n++) begin
      bit r, pv, iv, il;
      if (!lr_hold && ($urandom_range(0, 2) == 0)) begin
        lr_hold      = 1'b1;
        lr_hold_rd   = 5'($urandom_range(0, 31));
        lr_hold_data = $urandom;
      end
      r  = ($urandom_range(0, 99) == 0);
      pv = ($urandom_range(0, 3) != 0);
      iv = $urandom_range(0, 1);
      il = $urandom_range(0, 1);
      step(r, pv, 5'($urandom_range(0, 31)), $urandom, lr_hold, lr_hold_rd, lr_hold_data,
           iv, il, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), tk);
      if (tk) lr_hold = 1'b0;
    end

    @(posedge clk);
    #1;
    pipe_valid = 0; lr_valid = 0; iss_valid = 0; rst = 0;
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Owns the single write port of the 32x32 register file and shares it between two requesters:
  - the in-order pipeline writeback (PIPE);
  - the long-latency result return path for loads and mul/div (LR).
- Keeps a 32-entry pending-write scoreboard so the issue stage can stall on RAW and WAW hazards against in-flight long-latency results.
- Sits between the WB stage / LSU / mul-div return and the register file write inputs (wb_en, wb_data, W_rd_index).

Parameters:
STARVE_LIMIT, 4, number of consecutive cycles LR may wait with lr_valid high before PIPE is forcibly stalled
CNT_W, 3, width of the starvation counter; must satisfy 2**CNT_W > STARVE_LIMIT

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
pipe_valid  input  1  PIPE has a writeback this cycle
pipe_rd  input  5  PIPE destination index
pipe_data  input  32  PIPE write data
pipe_stall  output  1  PIPE must hold its request and freeze the pipeline
lr_valid  input  1  LR result available; must stay high with stable rd/data until accepted
lr_rd  input  5  LR destination index
lr_data  input  32  LR write data
lr_ready  output  1  LR result accepted this cycle
iss_valid  input  1  instruction issuing this cycle
iss_long  input  1  issuing instruction is long-latency (result returns via LR)
iss_rd  input  5  issuing instruction destination
rs1_index  input  5  issue-stage source 1
rs2_index  input  5  issue-stage source 2
rs1_busy  output  1  pending[rs1_index]
rs2_busy  output  1  pending[rs2_index]
rd_busy  output  1  pending[iss_rd] (WAW check)
wb_en  output  1  register file write enable
wb_rd  output  5  register file write index (drives W_rd_index)
wb_data  output  32  register file write data

Behaviour:
- FSM states NORMAL and FORCE_LR. Starvation counter wait_cnt is CNT_W bits wide. Scoreboard pending is 32 bits.
- Reset values:
  - state = NORMAL, wait_cnt = 0, pending = 0.
  - Consequently pipe_stall = 0, all busy outputs = 0.
  - lr_ready and wb_en follow their combinational equations below.
- Grant logic (combinational, zero latency):
  - In NORMAL, PIPE has fixed priority.
    - grant_pipe = pipe_valid.
    - grant_lr = lr_valid && !pipe_valid.
  - In FORCE_LR:
    - pipe_stall = 1 and pipe_valid is ignored.
    - grant_pipe = 0, grant_lr = lr_valid.
  - lr_ready = grant_lr.
  - wb_rd and wb_data are muxed from the granted source. With no grant they are 0.
  - wb_en = (grant_pipe || grant_lr) && wb_rd != 0.
  - A write to x0 is still granted and acknowledged, but it never asserts wb_en.
- Starvation counter:
  - NORMAL with lr_valid && !grant_lr: wait_cnt increments, saturating.
  - When wait_cnt reaches STARVE_LIMIT-1 and LR is still denied, next state = FORCE_LR.
  - Any grant_lr, or lr_valid low, clears wait_cnt to 0.
- FORCE_LR exit:
  - FORCE_LR with grant_lr: next state NORMAL, wait_cnt = 0. FORCE_LR therefore lasts exactly one cycle when LR holds valid.
  - FORCE_LR with lr_valid low (protocol violation): return to NORMAL with no write.
- Scoreboard, updated at posedge:
  - set_vec = onehot(iss_rd) when iss_valid && iss_long && iss_rd != 0.
  - clr_vec = onehot(lr_rd) when grant_lr.
  - pending <= (pending & ~clr_vec) | set_vec. Set wins on the same index.
- Busy outputs:
  - All busy outputs read registered pending with no same-cycle bypass. The register file write lands at the same edge, so the next-cycle read is consistent.
  - pending[0] is constant 0.
- PIPE writes never touch the scoreboard. The issue stage must not issue a writer to a busy rd (rd_busy).
- Reset mid-operation:
  - Pending entries and the FORCE_LR state are discarded.
  - A held LR request is re-arbitrated from NORMAL in the first cycle after rst deasserts.

Decomposition:
- Shared cpu package holds:
  - localparam REG_IDX_W = 5, XLEN = 32, NUM_REGS = 32;
  - enum typedef wbs_state_e {WBS_NORMAL, WBS_FORCE_LR}.
- One sub-module, rf_scoreboard:
  - contents: the 32-bit pending vector with set/clear ports and three read ports;
  - it is reused later by the FP register file.
- Arbitration FSM and muxing stay in the top module.

Test Plan:
- Reset, then all inputs 0 -> wb_en=0, pipe_stall=0, lr_ready=0, busy outputs 0. Then issue iss_long rd=5 -> next cycle rs1_index=5 gives rs1_busy=1.
- pipe_valid=1 rd=3 data=0xAAAA0001 with lr_valid=1 rd=5 data=0x1234 in the same cycle:
  - same cycle: wb_rd=3, lr_ready=0;
  - next cycle, with pipe_valid=0: wb_rd=5, wb_data=0x1234, lr_ready=1;
  - the following cycle: rs1_busy for 5 = 0.
- pipe_valid held 1 continuously with lr_valid=1 and STARVE_LIMIT=4:
  - lr_ready=0 for cycles 0-3;
  - cycle 4: pipe_stall=1, lr_ready=1, wb_rd=lr_rd;
  - cycle 5: pipe_stall=0, PIPE granted.
- lr_valid=1 rd=0 data=0xFFFF -> lr_ready=1, wb_en=0. Separately, iss_long with iss_rd=0 -> rd_busy stays 0.
- Same cycle: grant_lr clearing rd=7 while iss_long sets rd=7 -> pending[7] remains 1. Clear rd=7 with set rd=9 -> pending[7]=0, pending[9]=1.
- Assert rst while in FORCE_LR with pending=0x000000A0 -> next cycle pending=0, pipe_stall=0. A held lr_valid is granted in the first post-reset cycle only if pipe_valid=0.
